// File: rtl/fu_pipe_param.sv
// fu_pipe_param: parametrised ADD/SUB/MUL/DIV unit with valid/ready issue and CDB handshakes; FU_BACK_TO_BACK_EN allows accept on completion edge
module fu_pipe_param #(
  parameter int WIDTH   = 16,
  parameter int TAG_W   = 3,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [WIDTH-1:0] src_r1,
  input  logic [WIDTH-1:0] src_r2,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_err,
  output logic             busy
);
  localparam int MAX_LAT = ADD_LAT > MUL_LAT ? (ADD_LAT > DIV_LAT ? ADD_LAT : DIV_LAT) : (MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT);
  localparam int CW = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lat_m1;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] data_q, data_d, res;
  logic err_q, err_d, legal, div0, accept;
`ifdef FU_BACK_TO_BACK_EN
  assign issue_ready = state_q == IDLE || (state_q == WB && cdb_ready);
`else
  assign issue_ready = state_q == IDLE;
`endif
  assign accept = issue_valid && issue_ready && !flush;
  assign cdb_valid = state_q == WB;
  assign busy = state_q != IDLE;
  assign cdb_tag = tag_q;
  assign cdb_data = data_q;
  assign cdb_err = err_q;
  // decode the presented op into its result, error flag and latency
  always_comb begin
    div0 = ~|src_r1;
    legal = issue_op inside {4'b0000, 4'b0001, 4'b0100, 4'b0101};
    res = issue_op == 4'b0000 ? src_r2 + src_r1 :
          issue_op == 4'b0001 ? src_r2 - src_r1 :
          issue_op == 4'b0100 ? src_r2 * src_r1 :
          issue_op == 4'b0101 ? (div0 ? '1 : src_r2 / src_r1) : '0;
    lat_m1 = issue_op == 4'b0100 ? CW'(MUL_LAT - 1) :
             issue_op == 4'b0101 ? CW'(DIV_LAT - 1) : CW'(ADD_LAT - 1);
  end
  // next state: flush squashes, otherwise count down, retire, then accept
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    data_d = data_q;
    err_d = err_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      if (state_q == EXEC) begin
        state_d = cnt_q == '0 ? WB : EXEC;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      if (state_q == WB && cdb_ready) state_d = IDLE;
      if (accept) begin
        state_d = EXEC;
        cnt_d = lat_m1;
        tag_d = issue_tag;
        data_d = res;
        err_d = !legal || (issue_op == 4'b0101 && div0);
      end
    end
  end
  // state and registered outputs, reset clears everything
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fu_pipe_param.sv
// tb_fu_pipe_param: directed checks of fu_pipe_param latency, arithmetic, backpressure, flush and reset
module tb_fu_pipe_param;
  logic clock = 1'b0, reset_n, flush, issue_valid, issue_ready, cdb_valid, cdb_ready, cdb_err, busy;
  logic [3:0] issue_op;
  logic [2:0] issue_tag, cdb_tag;
  logic [15:0] src_r1, src_r2, cdb_data;
  int n_cmp = 0, n_fail = 0;
  fu_pipe_param dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_op(issue_op), .issue_tag(issue_tag),
    .src_r1(src_r1), .src_r2(src_r2), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_err(cdb_err), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic present(input logic [3:0] op, input logic [15:0] r2, input logic [15:0] r1, input logic [2:0] tag);
    issue_valid = 1'b1;
    issue_op = op;
    src_r2 = r2;
    src_r1 = r1;
    issue_tag = tag;
  endtask
  task automatic run(input string name, input logic [3:0] op, input logic [15:0] r2, input logic [15:0] r1,
                     input logic [2:0] tag, input int lat, input logic [15:0] ed, input logic ee);
    cdb_ready = 1'b1;
    present(op, r2, r1, tag);
    step;
    issue_valid = 1'b0;
    check({name, "_acc_busy"}, busy, 1);
    check({name, "_acc_valid"}, cdb_valid, 0);
    for (int i = 1; i < lat; i++) begin
      step;
      check({name, "_wait_valid"}, cdb_valid, 0);
    end
    step;
    check({name, "_valid"}, cdb_valid, 1);
    check({name, "_data"}, cdb_data, ed);
    check({name, "_tag"}, cdb_tag, tag);
    check({name, "_err"}, cdb_err, ee);
    step;
    check({name, "_done_valid"}, cdb_valid, 0);
    check({name, "_done_ready"}, issue_ready, 1);
  endtask
  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_op = 4'h0;
    issue_tag = 3'd0;
    src_r1 = 16'h0;
    src_r2 = 16'h0;
    cdb_ready = 1'b0;
    step;
    step;
    check("rst_valid", cdb_valid, 0);
    check("rst_data", cdb_data, 0);
    check("rst_tag", cdb_tag, 0);
    check("rst_err", cdb_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", issue_ready, 1);
    reset_n = 1'b1;
    step;
    run("add", 4'b0000, 16'h0005, 16'h0003, 3'd2, 1, 16'h0008, 1'b0);
    run("sub_wrap", 4'b0001, 16'h0001, 16'h0002, 3'd4, 1, 16'hFFFF, 1'b0);
    run("mul", 4'b0100, 16'h0100, 16'h0100, 3'd1, 2, 16'h0000, 1'b0);
    run("mul2", 4'b0100, 16'h0123, 16'h0011, 3'd6, 2, 16'h1353, 1'b0);
    run("div0", 4'b0101, 16'd100, 16'd0, 3'd3, 2, 16'hFFFF, 1'b1);
    run("div7", 4'b0101, 16'd100, 16'd7, 3'd5, 2, 16'd14, 1'b0);
    run("illegal", 4'b0010, 16'd9, 16'd9, 3'd7, 1, 16'h0000, 1'b1);
    cdb_ready = 1'b0;
    present(4'b0100, 16'd3, 16'd4, 3'd5);
    step;
    issue_valid = 1'b0;
    step;
    check("bp_wait", cdb_valid, 0);
    step;
    check("bp_valid0", cdb_valid, 1);
    present(4'b0000, 16'd1, 16'd1, 3'd1);
    for (int i = 0; i < 5; i++) begin
      step;
      check("bp_hold_valid", cdb_valid, 1);
      check("bp_hold_data", cdb_data, 16'd12);
      check("bp_hold_tag", cdb_tag, 3'd5);
      check("bp_hold_ready", issue_ready, 0);
    end
    issue_valid = 1'b0;
    cdb_ready = 1'b1;
    step;
    check("bp_release_valid", cdb_valid, 0);
    check("bp_release_data", cdb_data, 16'd12);
    check("bp_release_tag", cdb_tag, 3'd5);
    present(4'b0101, 16'd100, 16'd7, 3'd3);
    step;
    issue_valid = 1'b0;
    check("fl_exec", busy, 1);
    flush = 1'b1;
    present(4'b0000, 16'd2, 16'd2, 3'd6);
    step;
    flush = 1'b0;
    issue_valid = 1'b0;
    check("fl_busy", busy, 0);
    check("fl_ready", issue_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      check("fl_no_valid", cdb_valid, 0);
      check("fl_no_accept", busy, 0);
    end
    cdb_ready = 1'b0;
    present(4'b0000, 16'd1, 16'd1, 3'd7);
    step;
    issue_valid = 1'b0;
    step;
    check("rwb_valid", cdb_valid, 1);
    check("rwb_data", cdb_data, 16'd2);
    reset_n = 1'b0;
    flush = 1'b1;
    present(4'b0000, 16'd3, 16'd3, 3'd1);
    step;
    check("rwb_rst_valid", cdb_valid, 0);
    check("rwb_rst_data", cdb_data, 0);
    check("rwb_rst_tag", cdb_tag, 0);
    check("rwb_rst_busy", busy, 0);
    check("rwb_rst_ready", issue_ready, 1);
    reset_n = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    cdb_ready = 1'b1;
    step;
    present(4'b0000, 16'd5, 16'd3, 3'd1);
    step;
    present(4'b0001, 16'd9, 16'd4, 3'd2);
    check("b2b_exec_ready", issue_ready, 0);
    step;
    check("b2b_first_valid", cdb_valid, 1);
    check("b2b_first_data", cdb_data, 16'd8);
`ifdef FU_BACK_TO_BACK_EN
    check("b2b_ready_wb", issue_ready, 1);
    step;
    issue_valid = 1'b0;
    check("b2b_second_acc", busy, 1);
    check("b2b_gap_valid", cdb_valid, 0);
    step;
`else
    check("b2b_ready_wb", issue_ready, 0);
    step;
    check("b2b_bubble_busy", busy, 0);
    check("b2b_bubble_valid", cdb_valid, 0);
    step;
    issue_valid = 1'b0;
    check("b2b_second_acc", busy, 1);
    step;
`endif
    check("b2b_second_valid", cdb_valid, 1);
    check("b2b_second_data", cdb_data, 16'd5);
    check("b2b_second_tag", cdb_tag, 3'd2);
    step;
    check("b2b_end_valid", cdb_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
